psddivide_pipe_ctrl: RTL and testbench

- Parametrised successor of the team's sequential non-restoring divider.
- Adds signed/unsigned mode selectable per operation, an internal FSM with start/busy/done handshake, and divide-by-zero detection.
- Removes the external stop strobe: results are registered automatically.
- Sits as a standalone arithmetic peripheral driven by a controller or testbench in the Lab datapath.

---
 rtl/psddivide_pkg.sv | 21 ++
 rtl/psddivide_pipe_step.sv | 22 ++
 rtl/psddivide_pipe_ctrl.sv | 166 ++++++++++++++++
 tb/tb_psddivide_pipe_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/psddivide_pkg.sv
// Shared types, constants and helpers for the sequential non-restoring divider.
package psddivide_pkg;

   localparam int unsigned MAX_NBITS = 64;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StIter    = 2'd1,
      StCorrect = 2'd2
   } state_e;

   // Divide-by-zero quotient; sliced down to the operand width by the user.
   localparam logic [MAX_NBITS-1:0] DBZ_QUOTIENT = '1;

   // Two's-complement magnitude; the negative minimum maps to 2^(n-1) unsigned.
   function automatic logic [MAX_NBITS-1:0] twos_mag(input logic [MAX_NBITS-1:0] value,
                                                     input logic                 negative);
      return negative ? (~value + MAX_NBITS'(1)) : value;
   endfunction

endpackage

// File: rtl/psddivide_pipe_step.sv
// Combinational single non-restoring division iteration.
module psddivide_step #(
   parameter int unsigned NBITS = 32
) (
   input  logic [NBITS:0]   r,
   input  logic [NBITS-1:0] d,
   input  logic             next_bit,
   output logic [NBITS:0]   r_new,
   output logic             q_bit
);

   logic [NBITS:0] r_shift;
   logic [NBITS:0] d_ext;

   always_comb begin
      r_shift = {r[NBITS-1:0], next_bit};
      d_ext   = {1'b0, d};
      r_new   = r[NBITS] ? (r_shift + d_ext) : (r_shift - d_ext);
      q_bit   = ~r_new[NBITS];
   end

endmodule

// File: rtl/psddivide_pipe_ctrl.sv
// Sequential signed/unsigned non-restoring divider with start/busy/done handshake
// and divide-by-zero detection.
module psddivide_pipe_ctrl
   import psddivide_pkg::*;
#(
   parameter int unsigned NBITS = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             sign_mode,
   input  logic [NBITS-1:0] dividend,
   input  logic [NBITS-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [NBITS-1:0] quotient,
   output logic [NBITS-1:0] rest
);

   localparam int unsigned CNT_W = $clog2(NBITS + 1);

   state_e           state_q, state_d;
   logic [NBITS:0]   r_q, r_d;
   logic [NBITS-1:0] dq_q, dq_d;
   logic [NBITS-1:0] d_q, d_d;
   logic [NBITS-1:0] quotient_q, quotient_d;
   logic [NBITS-1:0] rest_q, rest_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic             zero_q, zero_d;
   logic             done_q, done_d;
   logic             dbz_q, dbz_d;

   logic                 dividend_neg, divisor_neg;
   logic [MAX_NBITS-1:0] dividend_ext, divisor_ext;
   logic [MAX_NBITS-1:0] dividend_mag_full, divisor_mag_full;
   logic [NBITS-1:0]     dividend_mag, divisor_mag;
   logic [NBITS-1:0]     rem_fix;
   logic [NBITS:0]       step_r;
   logic                 step_q;
   logic                 mag_unused;

   always_comb begin
      dividend_ext              = '0;
      divisor_ext               = '0;
      dividend_ext[NBITS-1:0]   = dividend;
      divisor_ext[NBITS-1:0]    = divisor;
      dividend_neg              = sign_mode & dividend[NBITS-1];
      divisor_neg               = sign_mode & divisor[NBITS-1];
      dividend_mag_full         = twos_mag(dividend_ext, dividend_neg);
      divisor_mag_full          = twos_mag(divisor_ext, divisor_neg);
      dividend_mag              = dividend_mag_full[NBITS-1:0];
      divisor_mag               = divisor_mag_full[NBITS-1:0];
      mag_unused                = ^{dividend_mag_full, divisor_mag_full};
      rem_fix = r_q[NBITS] ? (r_q[NBITS-1:0] + d_q) : r_q[NBITS-1:0];
   end

   // dq holds the remaining dividend bits; quotient bits shift in from the bottom.
   psddivide_step #(
      .NBITS(NBITS)
   ) u_step (
      .r       (r_q),
      .d       (d_q),
      .next_bit(dq_q[NBITS-1]),
      .r_new   (step_r),
      .q_bit   (step_q)
   );

   always_comb begin
      state_d    = state_q;
      r_d        = r_q;
      dq_d       = dq_q;
      d_d        = d_q;
      count_d    = count_q;
      qneg_d     = qneg_q;
      rneg_d     = rneg_q;
      zero_d     = zero_q;
      quotient_d = quotient_q;
      rest_d     = rest_q;
      dbz_d      = dbz_q;
      done_d     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               qneg_d  = dividend_neg ^ divisor_neg;
               rneg_d  = dividend_neg;
               d_d     = divisor_mag;
               r_d     = '0;
               count_d = '0;
               dbz_d   = 1'b0;
               if (divisor == '0) begin
                  zero_d  = 1'b1;
                  dq_d    = dividend;
                  state_d = StCorrect;
               end else begin
                  zero_d  = 1'b0;
                  dq_d    = dividend_mag;
                  state_d = StIter;
               end
            end
         end
         StIter: begin
            r_d     = step_r;
            dq_d    = {dq_q[NBITS-2:0], step_q};
            count_d = count_q + CNT_W'(1);
            if (count_q == CNT_W'(NBITS - 1)) begin
               state_d = StCorrect;
            end
         end
         StCorrect: begin
            done_d  = 1'b1;
            state_d = StIdle;
            if (zero_q) begin
               quotient_d = DBZ_QUOTIENT[NBITS-1:0];
               rest_d     = dq_q;
               dbz_d      = 1'b1;
            end else begin
               quotient_d = qneg_q ? -dq_q : dq_q;
               rest_d     = rneg_q ? -rem_fix : rem_fix;
               dbz_d      = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q    <= StIdle;
         r_q        <= '0;
         dq_q       <= '0;
         d_q        <= '0;
         count_q    <= '0;
         qneg_q     <= 1'b0;
         rneg_q     <= 1'b0;
         zero_q     <= 1'b0;
         quotient_q <= '0;
         rest_q     <= '0;
         done_q     <= 1'b0;
         dbz_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         r_q        <= r_d;
         dq_q       <= dq_d;
         d_q        <= d_d;
         count_q    <= count_d;
         qneg_q     <= qneg_d;
         rneg_q     <= rneg_d;
         zero_q     <= zero_d;
         quotient_q <= quotient_d;
         rest_q     <= rest_d;
         done_q     <= done_d;
         dbz_q      <= dbz_d;
      end
   end

   assign busy        = (state_q != StIdle);
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign quotient    = quotient_q;
   assign rest        = rest_q;

endmodule

// File: tb/tb_psddivide_pipe_ctrl.sv
// Directed scoreboard bench for the sequential divider at 32-bit and 8-bit widths.
module tb_psddivide_pipe_ctrl;

   typedef struct packed {
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
   } exp_t;

   logic        clock;
   logic        reset;
   logic        start, sign_mode;
   logic [31:0] dividend, divisor;
   logic        busy, done, div_by_zero;
   logic [31:0] quotient, rest;

   logic        start8, sign_mode8;
   logic [7:0]  dividend8, divisor8;
   logic        busy8, done8, dbz8;
   logic [7:0]  quotient8, rest8;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   e0_cyc = 0;
   exp_t sb[$];

   psddivide_pipe_ctrl #(
      .NBITS(32)
   ) u_dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .sign_mode  (sign_mode),
      .dividend   (dividend),
      .divisor    (divisor),
      .busy       (busy),
      .done       (done),
      .div_by_zero(div_by_zero),
      .quotient   (quotient),
      .rest       (rest)
   );

   psddivide_pipe_ctrl #(
      .NBITS(8)
   ) u_dut8 (
      .clock      (clock),
      .reset      (reset),
      .start      (start8),
      .sign_mode  (sign_mode8),
      .dividend   (dividend8),
      .divisor    (divisor8),
      .busy       (busy8),
      .done       (done8),
      .div_by_zero(dbz8),
      .quotient   (quotient8),
      .rest       (rest8)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_op(input logic sm, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er, input logic edbz);
      exp_t e;
      sign_mode = sm;
      dividend  = a;
      divisor   = b;
      start     = 1'b1;
      e.q       = eq;
      e.r       = er;
      e.dbz     = edbz;
      sb.push_back(e);
      @(posedge clock);
      #1;
      e0_cyc    = cyc;
      start     = 1'b0;
      sign_mode = ~sm;
      dividend  = $urandom();
      divisor   = $urandom();
      check("busy_after_start", 64'(busy), 64'd1);
      check("dbz_cleared_on_start", 64'(div_by_zero), 64'd0);
   endtask

   task automatic wait_done(input string tag, input int exp_lat, output int busy_cnt);
      bit   seen;
      int   lat;
      exp_t e;
      seen     = 1'b0;
      lat      = -1;
      busy_cnt = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clock);
         #1;
         if (done) begin
            seen = 1'b1;
            lat  = cyc - e0_cyc;
            break;
         end
         if (busy) busy_cnt++;
      end
      check({tag, " done_seen"}, 64'(seen), 64'd1);
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " busy_in_done"}, 64'(busy), 64'd0);
      check({tag, " sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check({tag, " quotient"}, 64'(quotient), 64'(e.q));
         check({tag, " rest"}, 64'(rest), 64'(e.r));
         check({tag, " div_by_zero"}, 64'(div_by_zero), 64'(e.dbz));
      end
   endtask

   initial begin
      int   bc;
      int   dones;
      int   lat8;
      bit   seen8;
      exp_t e8;

      reset      = 1'b0;
      start      = 1'b0;
      sign_mode  = 1'b0;
      dividend   = '0;
      divisor    = '0;
      start8     = 1'b0;
      sign_mode8 = 1'b0;
      dividend8  = '0;
      divisor8   = '0;
      repeat (3) @(posedge clock);
      #1;
      check("reset busy", 64'(busy), 64'd0);
      check("reset done", 64'(done), 64'd0);
      check("reset dbz", 64'(div_by_zero), 64'd0);
      check("reset quotient", 64'(quotient), 64'd0);
      check("reset rest", 64'(rest), 64'd0);
      check("reset8 quotient", 64'(quotient8), 64'd0);
      reset = 1'b1;

      start_op(1'b0, 32'd123456, 32'd789, 32'd156, 32'd372, 1'b0);
      wait_done("u_123456_789", 33, bc);
      check("u_123456_789 busy_cycles", 64'(bc), 64'd32);

      start_op(1'b0, 32'd100, 32'd0, 32'hFFFF_FFFF, 32'd100, 1'b1);
      wait_done("u_div0", 1, bc);
      @(posedge clock);
      #1;
      check("done_single_pulse", 64'(done), 64'd0);
      check("dbz_held", 64'(div_by_zero), 64'd1);

      start_op(1'b1, 32'd100, 32'd0, 32'hFFFF_FFFF, 32'd100, 1'b1);
      wait_done("s_div0", 1, bc);

      start_op(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
      wait_done("s_m7_2", 33, bc);

      start_op(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
      wait_done("s_7_m2", 33, bc);

      start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
      wait_done("s_min_m1", 33, bc);

      // Second start mid-iteration must be ignored.
      start_op(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
      repeat (5) @(posedge clock);
      #1;
      sign_mode = 1'b0;
      dividend  = 32'd10;
      divisor   = 32'd3;
      start     = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      check("busy_during_ignored_start", 64'(busy), 64'd1);
      wait_done("ignored_restart", 33, bc);

      // Start driven in the done cycle.
      start_op(1'b0, 32'd10, 32'd3, 32'd3, 32'd1, 1'b0);
      wait_done("back_to_back", 33, bc);

      // Reset mid-iteration aborts without a done pulse.
      start_op(1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0);
      repeat (5) @(posedge clock);
      #1;
      reset = 1'b0;
      @(posedge clock);
      #1;
      check("abort busy", 64'(busy), 64'd0);
      check("abort done", 64'(done), 64'd0);
      check("abort dbz", 64'(div_by_zero), 64'd0);
      check("abort quotient", 64'(quotient), 64'd0);
      check("abort rest", 64'(rest), 64'd0);
      reset = 1'b1;
      sb.delete();
      dones = 0;
      repeat (40) begin
         @(posedge clock);
         #1;
         if (done) dones++;
      end
      check("no_done_after_abort", 64'(dones), 64'd0);

      start_op(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
      wait_done("after_reset_9_3", 33, bc);

      // 8-bit instance.
      sign_mode8 = 1'b0;
      dividend8  = 8'd200;
      divisor8   = 8'd7;
      start8     = 1'b1;
      e8.q       = 32'd28;
      e8.r       = 32'd4;
      e8.dbz     = 1'b0;
      sb.push_back(e8);
      @(posedge clock);
      #1;
      e0_cyc    = cyc;
      start8    = 1'b0;
      dividend8 = 8'hA5;
      divisor8  = 8'h00;
      check("n8 busy_after_start", 64'(busy8), 64'd1);
      seen8 = 1'b0;
      lat8  = -1;
      for (int i = 0; i < 50; i++) begin
         @(posedge clock);
         #1;
         if (done8) begin
            seen8 = 1'b1;
            lat8  = cyc - e0_cyc;
            break;
         end
      end
      check("n8 done_seen", 64'(seen8), 64'd1);
      check("n8 latency", 64'(lat8), 64'd9);
      check("n8 sb_nonempty", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
         e8 = sb.pop_front();
         check("n8 quotient", 64'(quotient8), 64'(e8.q[7:0]));
         check("n8 rest", 64'(rest8), 64'(e8.r[7:0]));
         check("n8 div_by_zero", 64'(dbz8), 64'(e8.dbz));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
